// File: rtl/axi4_frame_reader_if.sv
// rtl/axi4_frame_reader_if.sv - AXI4 read address and read data channels
interface axi4_frame_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [DATA_WIDTH-1:0] RDATA;
  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;
  logic [1:0]            RRESP;

  modport master (
    output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
    input  ARREADY, RDATA, RVALID, RLAST, RRESP
  );

  modport slave (
    input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARCACHE, ARPROT, RREADY,
    output ARREADY, RDATA, RVALID, RLAST, RRESP
  );
endinterface

// File: rtl/axi4_frame_reader.sv
// rtl/axi4_frame_reader.sv - AXI4 read master fetching one frame per frame_start edge
// into the display FIFO, one fixed-length INCR burst outstanding at a time.
module axi4_frame_reader #(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int BURST_BEATS      = 64,
  parameter int BURSTS_PER_FRAME = 300,
  parameter int BYTES_PER_BURST  = 512
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  axi4_frame_reader_if.master       axi,
  output logic [AXI_DATA_WIDTH-1:0] fifo_din,
  output logic                      fifo_wr_en,
  input  logic                      fifo_prog_full,
  output logic                      busy,
  output logic                      reader_done,
  output logic                      rresp_err,
  output logic                      frame_overrun,
  output logic [1:0]                state
);
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADDR_SEND = 2'd1,
    DATA_RECV = 2'd2,
    NEXT      = 2'd3
  } state_t;

  localparam int                        ALIGN_BITS   = $clog2(BYTES_PER_BURST);
  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK   = ~AXI_ADDR_WIDTH'(BYTES_PER_BURST - 1);
  localparam logic [5:0]                LAST_BEAT    = 6'(BURST_BEATS - 1);
  localparam logic [8:0]                FRAME_BURSTS = 9'(BURSTS_PER_FRAME);

  state_t                    cur, nxt;
  logic                      frame_start_d1, start_pulse;
  logic [AXI_ADDR_WIDTH-1:0] base, base_nxt, araddr, araddr_nxt;
  logic                      arvalid, arvalid_nxt, rready;
  logic                      busy_nxt, done_nxt, err_nxt, ovr_nxt;
  logic [5:0]                beat_cnt, beat_nxt;
  logic [8:0]                burst_cnt, burst_nxt;
  logic                      r_hs;

  assign start_pulse = frame_start & ~frame_start_d1;
  assign rready      = (cur == DATA_RECV);
  assign r_hs        = axi.RVALID & rready;

  assign axi.ARADDR  = araddr;
  assign axi.ARVALID = arvalid;
  assign axi.ARLEN   = 8'(BURST_BEATS - 1);
  assign axi.ARSIZE  = 3'b011;
  assign axi.ARBURST = 2'b01;
  assign axi.ARCACHE = 4'b0011;
  assign axi.ARPROT  = 3'b000;
  assign axi.RREADY  = rready;

  assign fifo_din   = axi.RDATA;
  assign fifo_wr_en = r_hs;
  assign state      = cur;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      cur            <= IDLE;
      frame_start_d1 <= 1'b0;
      base           <= '0;
      araddr         <= '0;
      arvalid        <= 1'b0;
      busy           <= 1'b0;
      reader_done    <= 1'b0;
      rresp_err      <= 1'b0;
      frame_overrun  <= 1'b0;
      beat_cnt       <= '0;
      burst_cnt      <= '0;
    end else begin
      cur            <= nxt;
      frame_start_d1 <= frame_start;
      base           <= base_nxt;
      araddr         <= araddr_nxt;
      arvalid        <= arvalid_nxt;
      busy           <= busy_nxt;
      reader_done    <= done_nxt;
      rresp_err      <= err_nxt;
      frame_overrun  <= ovr_nxt;
      beat_cnt       <= beat_nxt;
      burst_cnt      <= burst_nxt;
    end
  end

  always_comb begin
    nxt         = cur;
    base_nxt    = base;
    araddr_nxt  = araddr;
    arvalid_nxt = arvalid;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = rresp_err;
    ovr_nxt     = frame_overrun;
    beat_nxt    = beat_cnt;
    burst_nxt   = burst_cnt;

    // A new edge mid-frame is dropped; the running frame keeps its latched base.
    if (start_pulse && busy) ovr_nxt = 1'b1;

    case (cur)
      IDLE: begin
        if (start_pulse) begin
          base_nxt  = FRAME_BASE_ADDR & ALIGN_MASK;
          burst_nxt = '0;
          busy_nxt  = 1'b1;
          nxt       = NEXT;
        end
      end
      NEXT: begin
        if (burst_cnt == FRAME_BURSTS) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
          nxt      = IDLE;
        end else if (!fifo_prog_full) begin
          araddr_nxt  = base + (AXI_ADDR_WIDTH'(burst_cnt) << ALIGN_BITS);
          arvalid_nxt = 1'b1;
          nxt         = ADDR_SEND;
        end
      end
      ADDR_SEND: begin
        if (arvalid && axi.ARREADY) begin
          arvalid_nxt = 1'b0;
          beat_nxt    = '0;
          nxt         = DATA_RECV;
        end
      end
      DATA_RECV: begin
        if (r_hs) begin
          beat_nxt = beat_cnt + 6'd1;
          if (axi.RRESP != 2'b00) err_nxt = 1'b1;
          // An early or late RLAST is flagged but still closes the burst.
          if (axi.RLAST) begin
            if (beat_cnt != LAST_BEAT) err_nxt = 1'b1;
            burst_nxt = burst_cnt + 9'd1;
            nxt       = NEXT;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_frame_reader.sv
// tb/tb_axi4_frame_reader.sv - scoreboard bench for axi4_frame_reader with an AXI slave model
module tb_axi4_frame_reader;
  logic        clk_100Mhz = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        fifo_prog_full = 1'b0;
  logic [31:0] frame_base_addr = '0;
  logic [63:0] fifo_din;
  logic        fifo_wr_en, busy, reader_done, rresp_err, frame_overrun;
  logic [1:0]  state;

  axi4_frame_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) axi();

  axi4_frame_reader dut (
    .clk_100Mhz      (clk_100Mhz),
    .rst             (rst),
    .frame_start     (frame_start),
    .FRAME_BASE_ADDR (frame_base_addr),
    .axi             (axi),
    .fifo_din        (fifo_din),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_prog_full  (fifo_prog_full),
    .busy            (busy),
    .reader_done     (reader_done),
    .rresp_err       (rresp_err),
    .frame_overrun   (frame_overrun),
    .state           (state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  logic [31:0] ar_q[$];
  logic [63:0] dq[$];
  int          n_chk = 0, n_pass = 0;
  int          ar_count = 0, wr_count = 0, done_count = 0, cyc = 0, last_rlast_cyc = 0;
  int          s_phase = 0, s_beat = 0, s_burst = 0, s_wait = 0;
  bit          slow_mode = 0, err_mode = 0, slow = 0;
  logic        ar_hs = 0, r_hs = 0, prev_av_wait = 0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor samples on the falling edge; slave drives 1 ns after the rising edge.
  initial begin
    axi.ARREADY = 0; axi.RVALID = 0; axi.RLAST = 0; axi.RRESP = 0; axi.RDATA = '0;
    forever begin
      @(negedge clk_100Mhz);
      ar_hs = axi.ARVALID && axi.ARREADY;
      r_hs  = axi.RVALID && axi.RREADY;
      if (!rst) begin
        if (prev_av_wait) begin
          chk("ar_hold_valid", axi.ARVALID, 1);
          chk("ar_hold_addr", axi.ARADDR, prev_addr);
        end
        if (ar_hs) begin
          ar_count++;
          if (ar_q.size() == 0) chk("ar_unexpected", ar_q.size(), 1);
          else chk("araddr", axi.ARADDR, ar_q.pop_front());
          chk("ar_attrs", {axi.ARLEN, axi.ARSIZE, axi.ARBURST, axi.ARCACHE, axi.ARPROT},
              {8'd63, 3'b011, 2'b01, 4'b0011, 3'b000});
        end
        if (fifo_wr_en) begin
          wr_count++;
          if (dq.size() == 0) chk("data_unexpected", dq.size(), 1);
          else chk("fifo_din", fifo_din, dq.pop_front());
        end
        if (r_hs && axi.RLAST) last_rlast_cyc = cyc;
        if (reader_done) begin
          done_count++;
          chk("done_latency", cyc - last_rlast_cyc, 2);
        end
      end
      prev_av_wait = !rst && axi.ARVALID && !ar_hs;
      prev_addr    = axi.ARADDR;
      @(posedge clk_100Mhz);
      cyc++;
      #1;
      if (rst) begin
        axi.ARREADY = 0; axi.RVALID = 0; axi.RLAST = 0; axi.RRESP = 0;
        s_phase = 0; s_beat = 0; s_burst = 0; s_wait = 0;
        ar_q.delete(); dq.delete();
      end else begin
        if (s_phase == 0) begin
          if (ar_hs) begin s_phase = 1; s_beat = 0; end
        end else if (r_hs) begin
          if (axi.RLAST) begin s_phase = 0; s_burst++; end
          else s_beat++;
        end
        slow = slow_mode && (s_burst < 12);
        if (s_phase == 0) begin
          axi.RVALID = 0; axi.RLAST = 0; axi.RRESP = 0;
          if (slow) begin
            s_wait = axi.ARVALID ? s_wait + 1 : 0;
            axi.ARREADY = (s_wait >= 7);
          end else axi.ARREADY = 1;
        end else begin
          axi.ARREADY = 0;
          s_wait = 0;
          if (!slow || !axi.RVALID) begin
            axi.RVALID = 1;
            axi.RDATA  = {$urandom, $urandom};
            axi.RLAST  = (s_beat == ((err_mode && s_burst == 7) ? 40 : 63));
            axi.RRESP  = (err_mode && s_burst == 3 && s_beat == 5) ? 2'b10 : 2'b00;
            dq.push_back(axi.RDATA);
          end else begin
            axi.RVALID = 0; axi.RLAST = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_100Mhz);
    #2;
  endtask

  task automatic start_frame(input logic [31:0] addr);
    logic [31:0] b;
    b = addr & 32'hFFFF_FE00;
    ar_count = 0; wr_count = 0; done_count = 0; s_burst = 0;
    for (int i = 0; i < 300; i++) ar_q.push_back(b + i * 512);
    frame_base_addr = addr;
    frame_start = 1;
    tick();
    frame_base_addr = $urandom;
    chk("start_arvalid_c1", axi.ARVALID, 0);
    chk("start_state_c1", state, 3);
    tick();
    chk("start_arvalid_c2", axi.ARVALID, 1);
    chk("start_araddr", axi.ARADDR, b);
    frame_start = 0;
  endtask

  task automatic wait_ar(input int n, input string tag);
    int k;
    k = 0;
    while (ar_count < n && k < 30000) begin tick(); k++; end
    chk(tag, ar_count >= n, 1);
  endtask

  task automatic finish_frame(input int exp_writes, input string tag);
    int k;
    k = 0;
    while (done_count == 0 && k < 50000) begin tick(); k++; end
    repeat (20) tick();
    chk({tag, "_done_once"}, done_count, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_ar_count"}, ar_count, 300);
    chk({tag, "_ar_left"}, ar_q.size(), 0);
    chk({tag, "_writes"}, wr_count, exp_writes);
    chk({tag, "_data_left"}, dq.size(), 0);
  endtask

  initial begin
    int av, k;
    repeat (3) tick();
    chk("rst_arvalid", axi.ARVALID, 0);
    chk("rst_araddr", axi.ARADDR, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", reader_done, 0);
    chk("rst_err", rresp_err, 0);
    chk("rst_ovr", frame_overrun, 0);
    chk("rst_state", state, 0);
    rst = 0;
    repeat (2) tick();

    // Frame A: ideal slave, prog_full stall after burst 10, overrun at burst 150
    start_frame(32'h1000_0000);
    wait_ar(11, "wait_burst10");
    fifo_prog_full = 1;
    av = 0;
    repeat (500) begin tick(); if (axi.ARVALID) av++; end
    chk("pf_no_arvalid", av, 0);
    chk("pf_ar_count", ar_count, 11);
    chk("pf_state", state, 3);
    fifo_prog_full = 0;
    tick();
    chk("pf_resume_arvalid", axi.ARVALID, 1);
    chk("pf_resume_addr", axi.ARADDR, 32'h1000_1600);
    wait_ar(150, "wait_burst150");
    chk("ovr_before", frame_overrun, 0);
    frame_start = 1;
    repeat (2) tick();
    frame_start = 0;
    chk("ovr_set", frame_overrun, 1);
    chk("ovr_busy", busy, 1);
    finish_frame(19200, "frameA");
    chk("frameA_err", rresp_err, 0);

    // Frame B: slow slave for the first bursts, bad RRESP and early RLAST
    slow_mode = 1; err_mode = 1;
    start_frame(32'h0800_01FF);
    wait_ar(3, "wait_burst2");
    chk("err_before", rresp_err, 0);
    finish_frame(19200 - 23, "frameB");
    chk("err_sticky", rresp_err, 1);
    chk("ovr_sticky", frame_overrun, 1);
    slow_mode = 0; err_mode = 0;

    // Frame C: reset mid-burst then restart from base
    start_frame(32'h2000_0123);
    k = 0;
    while (!(s_phase == 1 && s_burst == 100 && s_beat == 30) && k < 30000) begin tick(); k++; end
    chk("reach_b100_beat30", s_burst, 100);
    rst = 1;
    #1;
    chk("mid_rst_arvalid", axi.ARVALID, 0);
    chk("mid_rst_araddr", axi.ARADDR, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_err", rresp_err, 0);
    chk("mid_rst_ovr", frame_overrun, 0);
    chk("mid_rst_rready", axi.RREADY, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    repeat (3) tick();
    rst = 0;
    repeat (2) tick();
    start_frame(32'h2000_0123);
    wait_ar(3, "restart_3_bursts");
    chk("restart_busy", busy, 1);
    chk("restart_ar_left", ar_q.size(), 297);
    rst = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
